branch_resolution_queue: RTL and testbench
==========================================

Name: branch_resolution_queue

Overview:
In-order queue of in-flight conditional branches. It sits between fetch/decode and the tournament predictor's update port.
- At prediction time it captures PC, predicted direction and the global/local history snapshots.
- At resolution it compares the actual outcome against the head entry and drives the predictor's write-side inputs (write enable, outcome, branch_miss, write PC, history rollback values).
- On a mispredict it squashes all younger entries and pulses a front-end flush.

Parameters:
DEPTH, 8, number of in-flight branch entries (power of 2, >=2)
GLOBAL_HISTORY_LEN, 8, width of global history snapshot
LOCAL_HISTORY_LEN, 10, width of local history snapshot
PC_LEN, 16, width of stored PC bits

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
alloc_valid  in  1  fetch presents a predicted branch
alloc_ready  out  1  queue can accept an entry this cycle
alloc_pc  in  PC_LEN  branch PC bits
alloc_prediction  in  1  predicted direction (1 = taken)
alloc_global_history  in  GLOBAL_HISTORY_LEN  global history at prediction time
alloc_local_history  in  LOCAL_HISTORY_LEN  local history at prediction time
resolve_valid  in  1  oldest branch resolved this cycle
resolve_taken  in  1  actual direction of oldest branch
upd_write_enabled  out  1  predictor update strobe
upd_outcome  out  1  actual direction
upd_branch_miss  out  1  prediction != outcome
upd_pc  out  PC_LEN  PC of resolved branch
upd_global_history  out  GLOBAL_HISTORY_LEN  snapshot for rollback/update
upd_local_history  out  LOCAL_HISTORY_LEN  snapshot for rollback/update
flush  out  1  one-cycle front-end squash pulse
count  out  $clog2(DEPTH)+1  occupied entries
err_underflow  out  1  sticky: resolve_valid seen while empty

Behaviour:
- Reset (async): head=tail=0, count=0, state=RUN; all upd_* outputs, flush and err_underflow are 0. Entry storage need not be cleared.
- Circular buffer, head/tail pointers wrap modulo DEPTH. count is a separate register, so full/empty are unambiguous.
- alloc_ready = (state==RUN) && (count<DEPTH). It depends only on registered state; there is no same-cycle bypass from resolve.
- Alloc fires when alloc_valid && alloc_ready: the entry is written at tail and tail increments.
- Resolve fires when resolve_valid && count!=0: the head entry is read and head increments.
- resolve_valid with count==0: ignored; err_underflow set and held until reset.
- Alloc and resolve in the same cycle (no miss): both occur; count unchanged.
- Update latency 1 cycle. A resolve fired at cycle N makes upd_write_enabled=1 at N+1 for exactly one cycle, with:
  - upd_outcome = resolve_taken
  - upd_branch_miss = stored_prediction ^ resolve_taken
  - upd_pc and upd_*_history = stored entry values
- Outside update cycles all upd_* outputs are driven to 0.
- FSM states:
  - RUN: normal operation.
  - RUN -> FLUSH: resolve fires at N with a mispredict. At N+1: flush=1, count=0, tail=head. Every entry younger than the mispredicted one is discarded, including any alloc handshaked in cycle N (it counts as accepted, then squashed).
  - FLUSH: alloc_ready=0 for exactly one cycle; resolve_valid is ignored and does not set err_underflow.
  - FLUSH -> RUN unconditionally at N+2.
- Reset asserted mid-operation: queue empties immediately and any pending update/flush pulse is cancelled.
- No arithmetic beyond pointer increment; the count update is +1, -1 or 0, and never overflows because alloc is gated by alloc_ready.

Decomposition:
- Shared package bp_pkg holds:
  - GLOBAL_HISTORY_LEN / LOCAL_HISTORY_LEN defaults, shared with the tournament predictor
  - brq_state_t enum {RUN, FLUSH}
  - the packed entry struct {pc, prediction, ghist, lhist}
- One sub-module is natural: brq_storage, a DEPTH-entry register file with one write port and one async-read port holding the packed entry. Pointer, count, FSM and update logic stay in the top.

Test Plan:
1. Fill: 8 allocs, no resolve -> count=8, alloc_ready=0 on cycle after 8th; 9th alloc_valid not accepted; count stays 8.
2. Correct prediction: alloc pc=0x1234, pred=1, ghist=0xA5, lhist=0x2C3; resolve_taken=1 -> next cycle upd_write_enabled=1, upd_branch_miss=0, upd_pc=0x1234, upd_global_history=0xA5, flush=0.
3. Mispredict squash: allocs A(pred=0), B, C; resolve A taken=1 while D allocs same cycle -> next cycle upd_branch_miss=1, upd_pc=A, flush=1, count=0. Cycle after that alloc_ready=0, then alloc_ready=1. B, C and D are never seen on upd_*.
4. Wrap-around: 20 alloc/resolve pairs, all correct, DEPTH=8 -> upd_pc sequence matches alloc order exactly; count never exceeds 8.
5. Simultaneous alloc+resolve at count=3 with no miss -> count stays 3; FIFO order preserved.
6. Underflow and reset: resolve_valid with count=0 -> err_underflow=1, no upd pulse. Assert reset mid-stream with count=5 -> count=0, err_underflow=0, all outputs 0 immediately.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: history widths common to the tournament
// predictor and the resolution queue, queue FSM states and the entry layout.
package bp_pkg;

  localparam int GLOBAL_HISTORY_LEN = 8;
  localparam int LOCAL_HISTORY_LEN  = 10;
  localparam int PC_LEN             = 16;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } brq_state_t;

  // Field order matches the flat packing used by the queue's storage word.
  typedef struct packed {
    logic [PC_LEN-1:0]             pc;
    logic                          prediction;
    logic [GLOBAL_HISTORY_LEN-1:0] ghist;
    logic [LOCAL_HISTORY_LEN-1:0]  lhist;
  } brq_entry_t;

endpackage

// File: rtl/brq_storage.sv
// DEPTH-entry register file for branch queue entries: one synchronous write
// port at the tail and one combinational read port at the head.
module brq_storage #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 35
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  // Contents are only ever read after being written, so no reset is needed.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/branch_resolution_queue.sv
// In-order queue of in-flight conditional branches: resolves the head entry,
// drives the predictor update port one cycle later and squashes on a mispredict.
module branch_resolution_queue #(
  parameter int DEPTH              = 8,
  parameter int GLOBAL_HISTORY_LEN = bp_pkg::GLOBAL_HISTORY_LEN,
  parameter int LOCAL_HISTORY_LEN  = bp_pkg::LOCAL_HISTORY_LEN,
  parameter int PC_LEN             = bp_pkg::PC_LEN
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alloc_valid,
  output logic                          alloc_ready,
  input  logic [PC_LEN-1:0]             alloc_pc,
  input  logic                          alloc_prediction,
  input  logic [GLOBAL_HISTORY_LEN-1:0] alloc_global_history,
  input  logic [LOCAL_HISTORY_LEN-1:0]  alloc_local_history,
  input  logic                          resolve_valid,
  input  logic                          resolve_taken,
  output logic                          upd_write_enabled,
  output logic                          upd_outcome,
  output logic                          upd_branch_miss,
  output logic [PC_LEN-1:0]             upd_pc,
  output logic [GLOBAL_HISTORY_LEN-1:0] upd_global_history,
  output logic [LOCAL_HISTORY_LEN-1:0]  upd_local_history,
  output logic                          flush,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          err_underflow
);

  import bp_pkg::*;

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = PC_LEN + 1 + GLOBAL_HISTORY_LEN + LOCAL_HISTORY_LEN;

  brq_state_t                    state_q, state_d;
  logic [PTR_W-1:0]              head_q, head_d;
  logic [PTR_W-1:0]              tail_q, tail_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic                          err_q, err_d;
  logic                          flush_q, flush_d;
  logic                          upd_we_q, upd_we_d;
  logic                          upd_outcome_q, upd_outcome_d;
  logic                          upd_miss_q, upd_miss_d;
  logic [PC_LEN-1:0]             upd_pc_q, upd_pc_d;
  logic [GLOBAL_HISTORY_LEN-1:0] upd_gh_q, upd_gh_d;
  logic [LOCAL_HISTORY_LEN-1:0]  upd_lh_q, upd_lh_d;

  logic [ENTRY_W-1:0]            wr_data;
  logic [ENTRY_W-1:0]            rd_data;
  logic [PC_LEN-1:0]             rd_pc;
  logic                          rd_prediction;
  logic [GLOBAL_HISTORY_LEN-1:0] rd_gh;
  logic [LOCAL_HISTORY_LEN-1:0]  rd_lh;
  logic                          alloc_fire;
  logic                          resolve_fire;
  logic                          mispredict;

  assign wr_data = {alloc_pc, alloc_prediction, alloc_global_history, alloc_local_history};

  brq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_storage (
    .clk     (clk),
    .wr_en   (alloc_fire),
    .wr_addr (tail_q),
    .wr_data (wr_data),
    .rd_addr (head_q),
    .rd_data (rd_data)
  );

  assign rd_pc         = rd_data[ENTRY_W-1 -: PC_LEN];
  assign rd_prediction = rd_data[GLOBAL_HISTORY_LEN + LOCAL_HISTORY_LEN];
  assign rd_gh         = rd_data[LOCAL_HISTORY_LEN +: GLOBAL_HISTORY_LEN];
  assign rd_lh         = rd_data[LOCAL_HISTORY_LEN-1:0];

  // Readiness comes from registered state only; a same-cycle resolve never frees a slot early.
  assign alloc_ready  = (state_q == RUN) && (count_q != CNT_W'(DEPTH));
  assign alloc_fire   = alloc_valid && alloc_ready;
  assign resolve_fire = resolve_valid && (state_q == RUN) && (count_q != '0);
  assign mispredict   = resolve_fire && (rd_prediction ^ resolve_taken);

  always_comb begin
    state_d       = state_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    err_d         = err_q;
    flush_d       = 1'b0;
    upd_we_d      = 1'b0;
    upd_outcome_d = 1'b0;
    upd_miss_d    = 1'b0;
    upd_pc_d      = '0;
    upd_gh_d      = '0;
    upd_lh_d      = '0;

    if (alloc_fire) begin
      tail_d = tail_q + 1'b1;
    end
    if (resolve_fire) begin
      head_d        = head_q + 1'b1;
      upd_we_d      = 1'b1;
      upd_outcome_d = resolve_taken;
      upd_miss_d    = rd_prediction ^ resolve_taken;
      upd_pc_d      = rd_pc;
      upd_gh_d      = rd_gh;
      upd_lh_d      = rd_lh;
    end

    if (alloc_fire && !resolve_fire) begin
      count_d = count_q + 1'b1;
    end else if (!alloc_fire && resolve_fire) begin
      count_d = count_q - 1'b1;
    end

    if (resolve_valid && (state_q == RUN) && (count_q == '0)) begin
      err_d = 1'b1;
    end

    case (state_q)
      RUN: begin
        // Discard everything younger than the mispredicted head, including this cycle's alloc.
        if (mispredict) begin
          state_d = FLUSH;
          flush_d = 1'b1;
          count_d = '0;
          tail_d  = head_q + 1'b1;
        end
      end
      FLUSH: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      err_q         <= 1'b0;
      flush_q       <= 1'b0;
      upd_we_q      <= 1'b0;
      upd_outcome_q <= 1'b0;
      upd_miss_q    <= 1'b0;
      upd_pc_q      <= '0;
      upd_gh_q      <= '0;
      upd_lh_q      <= '0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      err_q         <= err_d;
      flush_q       <= flush_d;
      upd_we_q      <= upd_we_d;
      upd_outcome_q <= upd_outcome_d;
      upd_miss_q    <= upd_miss_d;
      upd_pc_q      <= upd_pc_d;
      upd_gh_q      <= upd_gh_d;
      upd_lh_q      <= upd_lh_d;
    end
  end

  assign upd_write_enabled  = upd_we_q;
  assign upd_outcome        = upd_outcome_q;
  assign upd_branch_miss    = upd_miss_q;
  assign upd_pc             = upd_pc_q;
  assign upd_global_history = upd_gh_q;
  assign upd_local_history  = upd_lh_q;
  assign flush              = flush_q;
  assign count              = count_q;
  assign err_underflow      = err_q;

endmodule

// File: tb/tb_branch_resolution_queue.sv
// Randomized and directed bench for branch_resolution_queue, checked against a
// queue-based model of in-flight branches kept in the bench.
module tb_branch_resolution_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [15:0] alloc_pc;
  logic        alloc_prediction;
  logic [7:0]  alloc_global_history;
  logic [9:0]  alloc_local_history;
  logic        resolve_valid;
  logic        resolve_taken;
  logic        upd_write_enabled;
  logic        upd_outcome;
  logic        upd_branch_miss;
  logic [15:0] upd_pc;
  logic [7:0]  upd_global_history;
  logic [9:0]  upd_local_history;
  logic        flush;
  logic [3:0]  count;
  logic        err_underflow;

  branch_resolution_queue #(
    .DEPTH              (DEPTH),
    .GLOBAL_HISTORY_LEN (8),
    .LOCAL_HISTORY_LEN  (10),
    .PC_LEN             (16)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .alloc_valid          (alloc_valid),
    .alloc_ready          (alloc_ready),
    .alloc_pc             (alloc_pc),
    .alloc_prediction     (alloc_prediction),
    .alloc_global_history (alloc_global_history),
    .alloc_local_history  (alloc_local_history),
    .resolve_valid        (resolve_valid),
    .resolve_taken        (resolve_taken),
    .upd_write_enabled    (upd_write_enabled),
    .upd_outcome          (upd_outcome),
    .upd_branch_miss      (upd_branch_miss),
    .upd_pc               (upd_pc),
    .upd_global_history   (upd_global_history),
    .upd_local_history    (upd_local_history),
    .flush                (flush),
    .count                (count),
    .err_underflow        (err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    bit          pred;
    logic [7:0]  gh;
    logic [9:0]  lh;
  } br_t;

  br_t mq[$];
  bit  m_flush;
  bit  m_err;
  int  n_tests;
  int  n_fail;
  int  max_count;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; the model decides what the queue must do with it.
  task automatic step(input bit av, input logic [15:0] pc, input bit pred,
                      input logic [7:0] gh, input logic [9:0] lh,
                      input bit rv, input bit rt);
    bit   ready, afire, rfire, under;
    bit   e_we, e_out, e_miss;
    logic [15:0] e_pc;
    logic [7:0]  e_gh;
    logic [9:0]  e_lh;
    br_t  e, n;
    alloc_valid          = av;
    alloc_pc             = pc;
    alloc_prediction     = pred;
    alloc_global_history = gh;
    alloc_local_history  = lh;
    resolve_valid        = rv;
    resolve_taken        = rt;

    ready = !m_flush && (mq.size() < DEPTH);
    chk("alloc_ready", {31'd0, alloc_ready}, {31'd0, ready});
    afire = av && ready;
    rfire = rv && !m_flush && (mq.size() > 0);
    under = rv && !m_flush && (mq.size() == 0);
    e_we = 0; e_out = 0; e_miss = 0; e_pc = '0; e_gh = '0; e_lh = '0;
    if (rfire) begin
      e      = mq.pop_front();
      e_we   = 1;
      e_out  = rt;
      e_miss = e.pred ^ rt;
      e_pc   = e.pc;
      e_gh   = e.gh;
      e_lh   = e.lh;
    end
    if (afire) begin
      n.pc = pc; n.pred = pred; n.gh = gh; n.lh = lh;
      mq.push_back(n);
    end
    if (rfire && e_miss) mq.delete();
    m_flush = rfire && e_miss;
    m_err   = m_err || under;

    @(posedge clk);
    #1;
    chk("upd_we",      {31'd0, upd_write_enabled}, {31'd0, e_we});
    chk("upd_outcome", {31'd0, upd_outcome},       {31'd0, e_out});
    chk("upd_miss",    {31'd0, upd_branch_miss},   {31'd0, e_miss});
    chk("upd_pc",      {16'd0, upd_pc},            {16'd0, e_pc});
    chk("upd_ghist",   {24'd0, upd_global_history}, {24'd0, e_gh});
    chk("upd_lhist",   {22'd0, upd_local_history},  {22'd0, e_lh});
    chk("flush",       {31'd0, flush},             {31'd0, m_flush});
    chk("count",       {28'd0, count},             32'(mq.size()));
    chk("err_uflow",   {31'd0, err_underflow},     {31'd0, m_err});
    if (int'(count) > max_count) max_count = int'(count);
    $display("[TB] t=%0t av=%0d rv=%0d rt=%0d -> we=%0d miss=%0d pc=%h flush=%0d count=%0d",
             $time, av, rv, rt, upd_write_enabled, upd_branch_miss, upd_pc, flush, count);
    alloc_valid   = 1'b0;
    resolve_valid = 1'b0;
  endtask

  task automatic alloc_rand(input bit pred);
    step(1'b1, 16'($urandom), pred, 8'($urandom), 10'($urandom), 1'b0, 1'b0);
  endtask

  task automatic resolve_ok();
    bit p;
    p = (mq.size() > 0) ? mq[0].pred : 1'b0;
    step(1'b0, '0, 1'b0, '0, '0, 1'b1, p);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_count"}, {28'd0, count}, 32'd0);
    chk({tag, "_err"},   {31'd0, err_underflow}, 32'd0);
    chk({tag, "_we"},    {31'd0, upd_write_enabled}, 32'd0);
    chk({tag, "_miss"},  {31'd0, upd_branch_miss}, 32'd0);
    chk({tag, "_pc"},    {16'd0, upd_pc}, 32'd0);
    chk({tag, "_flush"}, {31'd0, flush}, 32'd0);
    chk({tag, "_ready"}, {31'd0, alloc_ready}, 32'd1);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; max_count = 0;
    m_flush = 0; m_err = 0;
    alloc_valid = 0; alloc_pc = '0; alloc_prediction = 0;
    alloc_global_history = '0; alloc_local_history = '0;
    resolve_valid = 0; resolve_taken = 0;
    reset = 1'b1;
    #2;
    check_all_zero("reset");
    #10 reset = 1'b0;
    @(posedge clk); #1;

    // Fill to capacity; the ninth alloc is refused and count holds.
    for (int i = 0; i < DEPTH; i++) alloc_rand(1'b1);
    chk("full_count", {28'd0, count}, 32'd8);
    alloc_rand(1'b1);
    chk("full_hold", {28'd0, count}, 32'd8);
    while (mq.size() > 0) resolve_ok();

    // Correct prediction with known fields.
    step(1'b1, 16'h1234, 1'b1, 8'hA5, 10'h2C3, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b1);
    chk("dir_pc", {16'd0, upd_pc}, 32'h1234);

    // Mispredict on A while D allocates; then the one-cycle flush window.
    step(1'b1, 16'hAAAA, 1'b0, 8'h11, 10'h011, 1'b0, 1'b0);
    step(1'b1, 16'hBBBB, 1'b1, 8'h22, 10'h022, 1'b0, 1'b0);
    step(1'b1, 16'hCCCC, 1'b1, 8'h33, 10'h033, 1'b0, 1'b0);
    step(1'b1, 16'hDDDD, 1'b1, 8'h44, 10'h044, 1'b1, 1'b1);
    chk("squash_pc", {16'd0, upd_pc}, 32'hAAAA);
    step(1'b1, 16'hEEEE, 1'b1, 8'h55, 10'h055, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);

    // Wrap-around: 20 alloc/resolve pairs.
    for (int i = 0; i < 20; i++) begin
      alloc_rand(1'($urandom));
      resolve_ok();
    end

    // Simultaneous alloc and correct resolve at count 3.
    for (int i = 0; i < 3; i++) alloc_rand(1'($urandom));
    step(1'b1, 16'h5A5A, 1'b0, 8'h5A, 10'h15A, 1'b1, mq[0].pred);
    chk("simul_count", {28'd0, count}, 32'd3);
    while (mq.size() > 0) resolve_ok();

    // Underflow on empty queue.
    step(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);

    // Randomized traffic, biased toward correct predictions.
    for (int i = 0; i < 600; i++) begin
      bit av, rv, rt;
      av = ($urandom % 3) != 0;
      rv = ($urandom % 2) != 0;
      rt = (mq.size() > 0 && ($urandom % 5) != 0) ? mq[0].pred : 1'($urandom);
      step(av, 16'($urandom), 1'($urandom), 8'($urandom), 10'($urandom), rv, rt);
    end
    chk("max_count", 32'(max_count <= DEPTH), 32'd1);

    // Reset mid-stream with a pending update pulse and the sticky error set.
    while (mq.size() > 0) resolve_ok();
    step(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) alloc_rand(1'b1);
    resolve_ok();
    chk("pre_reset_count", {28'd0, count}, 32'd5);
    #1 reset = 1'b1;
    #1 check_all_zero("midreset");
    #2 reset = 1'b0;
    mq.delete();
    m_flush = 0;
    m_err   = 0;
    @(posedge clk); #1;
    alloc_rand(1'b0);
    resolve_ok();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
